// File: rtl/key_press_arbiter_if.sv
// -----------------------------------------------------------------------------
// key_press_arbiter_if
// Bundles the raw button inputs and the accepted-press outputs of the shared
// debounce controller.
//   key_raw   : raw button levels, 1 = pressed, asynchronous to the clock
//   key_valid : one-cycle pulse per accepted press
//   key_code  : index of the granted key, held until the next grant
//   key_held  : one-hot mark of the accepted key while it is held
//   busy      : controller is qualifying or tracking a key
// The master modport is the button/consumer side; the slave modport is the
// debounce controller itself.
// -----------------------------------------------------------------------------
interface key_press_arbiter_if #(
    parameter int N_KEYS = 4
);
    localparam int CODE_W = $clog2(N_KEYS);

    logic [N_KEYS-1:0] key_raw;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic [N_KEYS-1:0] key_held;
    logic              busy;

    modport master (
        output key_raw,
        input  key_valid,
        input  key_code,
        input  key_held,
        input  busy
    );

    modport slave (
        input  key_raw,
        output key_valid,
        output key_code,
        output key_held,
        output busy
    );
endinterface

// File: rtl/key_press_arbiter.sv
// -----------------------------------------------------------------------------
// key_press_arbiter
// Shared debounce controller: one settle counter is granted to one raw key at
// a time with round-robin arbitration. A key is accepted only after it stays
// stable for CNT_MAX cycles; release is qualified the same way.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : key_press_arbiter_if.slave (key_raw in; key_valid, key_code,
//           key_held, busy out)
// -----------------------------------------------------------------------------
module key_press_arbiter #(
    parameter int N_KEYS  = 4,
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_press_arbiter_if.slave   bus
);
    localparam int CODE_W = $clog2(N_KEYS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_PRESSED = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [N_KEYS-1:0] key_sync_p0;
    logic [N_KEYS-1:0] key_s;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] sel;
    logic [CODE_W-1:0] ptr;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic [N_KEYS-1:0] key_held;
    logic [CODE_W:0]   pick;

    // Round-robin search starting just after the last released key. Scanning
    // the offsets downward lets the nearest requester overwrite farther ones.
    // Result is {found, index}.
    function automatic logic [CODE_W:0] rr_search(
        input logic [N_KEYS-1:0] req,
        input logic [CODE_W-1:0] last
    );
        logic [CODE_W:0]   res;
        logic [CODE_W-1:0] idx;
        res = '0;
        for (int off = N_KEYS; off >= 1; off--) begin
            idx = CODE_W'((int'(last) + off) % N_KEYS);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign pick = rr_search(key_s, ptr);

    // Stage p0 -> key_s: two-flop synchroniser per raw key bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sync_p0 <= '0;
            key_s       <= '0;
        end else begin
            key_sync_p0 <= bus.key_raw;
            key_s       <= key_sync_p0;
        end
    end

    // Arbitration / qualification FSM operating on synchronised levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sel       <= '0;
            ptr       <= CODE_W'(N_KEYS - 1);
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= '0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick[CODE_W]) begin
                        sel      <= pick[CODE_W-1:0];
                        key_code <= pick[CODE_W-1:0];
                        cnt      <= '0;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!key_s[sel]) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= S_PRESSED;
                        key_valid <= 1'b1;
                        key_held  <= N_KEYS'(1) << sel;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PRESSED: begin
                    if (!key_s[sel]) begin
                        cnt   <= '0;
                        state <= S_RELEASE;
                    end
                end
                default: begin
                    // A high sample while releasing is a bounce: go back to
                    // PRESSED without a second pulse.
                    if (key_s[sel]) begin
                        cnt   <= '0;
                        state <= S_PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state    <= S_IDLE;
                        key_held <= '0;
                        ptr      <= sel;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.key_valid = key_valid;
    assign bus.key_code  = key_code;
    assign bus.key_held  = key_held;
    assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_key_press_arbiter.sv
// -----------------------------------------------------------------------------
// tb_key_press_arbiter
// Directed bench for key_press_arbiter with N_KEYS=4, CNT_MAX=4. A timestamp
// based model predicts every output each cycle; directed literal checks pin
// the press/release latencies and granted codes.
// -----------------------------------------------------------------------------
module tb_key_press_arbiter;
    localparam int N_KEYS  = 4;
    localparam int CNT_MAX = 4;
    localparam int CNT_W   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    key_press_arbiter_if #(.N_KEYS(N_KEYS)) bus ();

    key_press_arbiter #(
        .N_KEYS (N_KEYS),
        .CNT_MAX(CNT_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 idle, 1 qualifying press, 2 held, 3 qualifying release.
    // Timing is tracked with edge timestamps rather than a counter.
    logic [N_KEYS-1:0] m_meta = '0;
    logic [N_KEYS-1:0] m_s    = '0;
    logic [N_KEYS-1:0] s_pre  = '0;
    int   m_phase = 0;
    int   m_grant = 0;
    int   m_ptr   = N_KEYS - 1;
    int   m_code  = 0;
    int   m_t     = 0;
    int   edge_n  = 0;
    int   j       = 0;
    bit   found   = 0;
    logic m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_meta  = '0;
            m_s     = '0;
            m_phase = 0;
            m_grant = 0;
            m_ptr   = N_KEYS - 1;
            m_code  = 0;
            m_t     = 0;
            m_valid = 1'b0;
        end else begin
            edge_n++;
            s_pre   = m_s;
            m_s     = m_meta;
            m_meta  = bus.key_raw;
            m_valid = 1'b0;
            case (m_phase)
                0: begin
                    found = 0;
                    for (int off = 1; off <= N_KEYS; off++) begin
                        j = (m_ptr + off) % N_KEYS;
                        if (!found && s_pre[j]) begin
                            found   = 1;
                            m_grant = j;
                        end
                    end
                    if (found) begin
                        m_phase = 1;
                        m_t     = edge_n;
                        m_code  = m_grant;
                    end
                end
                1: begin
                    if (!s_pre[m_grant]) m_phase = 0;
                    else if (edge_n - m_t == CNT_MAX) begin
                        m_phase = 2;
                        m_valid = 1'b1;
                    end
                end
                2: begin
                    if (!s_pre[m_grant]) begin
                        m_phase = 3;
                        m_t     = edge_n;
                    end
                end
                default: begin
                    if (s_pre[m_grant]) m_phase = 2;
                    else if (edge_n - m_t == CNT_MAX) begin
                        m_phase = 0;
                        m_ptr   = m_grant;
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    int n_pulses   = 0;
    int pulse_edge = -1;
    int pulse_code = -1;
    int rise_edge  = -1;
    int fall_edge  = -1;
    bit busy_prev  = 0;
    logic [31:0] exp_held;

    always @(negedge clk) begin
        exp_held = (m_phase >= 2) ? (32'd1 << m_grant) : 32'd0;
        check("key_valid", 32'(bus.key_valid), 32'(m_valid));
        check("key_code",  32'(bus.key_code),  32'(m_code));
        check("key_held",  32'(bus.key_held),  exp_held);
        check("busy",      32'(bus.busy),      32'(m_phase != 0));
        if (bus.key_valid === 1'b1) begin
            n_pulses++;
            pulse_edge = edge_n;
            pulse_code = int'(bus.key_code);
        end
        if (bus.busy === 1'b1 && !busy_prev) rise_edge = edge_n;
        if (bus.busy !== 1'b1 && busy_prev)  fall_edge = edge_n;
        busy_prev = (bus.busy === 1'b1);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int k;
    int r;
    int p0;

    initial begin
        bus.key_raw = 4'b1111;
        #2 rst_n = 1'b0;

        // Reset with all keys pressed
        tick(3);
        check("rst_valid", 32'(bus.key_valid), 32'd0);
        check("rst_code",  32'(bus.key_code),  32'd0);
        check("rst_held",  32'(bus.key_held),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        rst_n = 1'b1;
        k  = edge_n + 1;
        p0 = n_pulses;
        tick(8);
        check("s1_pulse_edge", 32'(pulse_edge), 32'(k + 6));
        check("s1_code",       32'(pulse_code), 32'd0);
        check("s1_count",      32'(n_pulses - p0), 32'd1);
        bus.key_raw = 4'b0000;
        tick(12);

        // Clean press of key 1
        bus.key_raw = 4'b0010;
        k  = edge_n + 1;
        p0 = n_pulses;
        tick(8);
        check("s2_held_mid", 32'(bus.key_held), 32'h2);
        tick(12);
        bus.key_raw = 4'b0000;
        r = edge_n + 1;
        tick(12);
        check("s2_pulse_edge", 32'(pulse_edge), 32'(k + 6));
        check("s2_code",       32'(pulse_code), 32'd1);
        check("s2_count",      32'(n_pulses - p0), 32'd1);
        check("s2_busy_rise",  32'(rise_edge), 32'(k + 2));
        check("s2_busy_fall",  32'(fall_edge), 32'(r + 6));

        // Bouncy press of key 0
        p0 = n_pulses;
        begin
            logic [6:0] pat;
            pat = 7'b1110110;
            for (int i = 6; i >= 0; i--) begin
                bus.key_raw = {3'b000, pat[i]};
                tick(1);
            end
        end
        bus.key_raw = 4'b0001;
        k = edge_n + 1;
        tick(10);
        check("s3_pulse_edge", 32'(pulse_edge), 32'(k + 6));
        check("s3_count",      32'(n_pulses - p0), 32'd1);
        bus.key_raw = 4'b0000;
        tick(12);

        // Release bounce on key 3
        bus.key_raw = 4'b1000;
        p0 = n_pulses;
        tick(10);
        check("s4_code", 32'(bus.key_code), 32'd3);
        bus.key_raw = 4'b0000;
        r = edge_n + 1;
        tick(2);
        bus.key_raw = 4'b1000;
        tick(1);
        bus.key_raw = 4'b0000;
        tick(4);
        check("s4_held_bounce", 32'(bus.key_held), 32'h8);
        tick(10);
        check("s4_busy_fall", 32'(fall_edge), 32'(r + 9));
        check("s4_count",     32'(n_pulses - p0), 32'd1);

        // Round-robin between keys 0 and 2
        bus.key_raw = 4'b0101;
        k = edge_n + 1;
        tick(10);
        check("s5_first_edge", 32'(pulse_edge), 32'(k + 6));
        check("s5_first_code", 32'(pulse_code), 32'd0);
        bus.key_raw = 4'b0100;
        r = edge_n + 1;
        tick(14);
        check("s5_second_edge", 32'(pulse_edge), 32'(r + 11));
        check("s5_second_code", 32'(pulse_code), 32'd2);
        bus.key_raw = 4'b0000;
        tick(12);
        bus.key_raw = 4'b0101;
        k = edge_n + 1;
        tick(10);
        check("s5_third_edge", 32'(pulse_edge), 32'(k + 6));
        check("s5_third_code", 32'(pulse_code), 32'd0);
        bus.key_raw = 4'b0000;
        tick(12);

        // Reset while qualifying key 1 (counter at 2)
        bus.key_raw = 4'b0010;
        k  = edge_n + 1;
        p0 = n_pulses;
        tick(5);
        check("s6_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("s6_busy",  32'(bus.busy),      32'd0);
        check("s6_valid", 32'(bus.key_valid), 32'd0);
        check("s6_held",  32'(bus.key_held),  32'd0);
        check("s6_code",  32'(bus.key_code),  32'd0);
        tick(2);
        bus.key_raw = 4'b0000;
        rst_n = 1'b1;
        tick(10);
        check("s6_count", 32'(n_pulses - p0), 32'd0);

        // Key held through reset is re-qualified from scratch
        bus.key_raw = 4'b0100;
        tick(3);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        k  = edge_n + 1;
        p0 = n_pulses;
        tick(8);
        check("s7_pulse_edge", 32'(pulse_edge), 32'(k + 6));
        check("s7_code",       32'(pulse_code), 32'd2);
        check("s7_count",      32'(n_pulses - p0), 32'd1);
        bus.key_raw = 4'b0000;
        tick(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_press_arbiter.md
# key_press_arbiter

Shared debounce controller for the LED display lab's push-buttons. It owns a single settle counter and grants it to one raw key at a time, using round-robin arbitration. A key is accepted only after it has been stable through the full debounce window. For each accepted press, the block emits one `key_valid` pulse with the key index on `key_code`. It sits between the board buttons and the display control logic, and it is the only path by which button presses reach that logic.

## Interface
- `N_KEYS`, 4: number of raw key inputs; legal range 2..16.
- `CNT_MAX`, 1_000_000: number of stable cycles required for both press and release; must be ≥2.
- `CNT_W`, 20: settle counter width; must satisfy 2^CNT_W > CNT_MAX.
- `CODE_W` (localparam): `$clog2(N_KEYS)`.

Ports:
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_raw` input N_KEYS: raw button levels, 1 = pressed, asynchronous to `clk`.
- `key_valid` output 1: one-cycle pulse per accepted press.
- `key_code` output CODE_W: index of the granted key.
- `key_held` output N_KEYS: one-hot; marks the accepted key while it is considered held.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **Input synchronisation:** `key_raw` passes through a 2-flop synchroniser per bit, producing `key_s`. All decisions use `key_s` only.
- **States:** IDLE, SETTLE, PRESSED, RELEASE. There is one counter `cnt` (CNT_W bits) and one grant index `sel`.
- **Round-robin pointer:** `ptr` holds the index of the last key that completed a release.
- **IDLE:**
  - If any `key_s` bit is 1, set `sel` to the first set bit, searching from (ptr+1) mod N_KEYS upward with wrap.
  - Set `key_code`←sel, clear `cnt`, and go to SETTLE.
- **SETTLE:**
  - If `key_s[sel]`=0: clear `cnt` and go to IDLE (abort; no output).
  - Else if `cnt`==CNT_MAX-1: go to PRESSED, set `key_valid`, set `key_held[sel]`.
  - Else increment `cnt`.
- **PRESSED:**
  - `key_valid` clears after one cycle.
  - If `key_s[sel]`=0: clear `cnt` and go to RELEASE.
- **RELEASE:**
  - If `key_s[sel]`=1: clear `cnt` and return to PRESSED (bounce on release). No new `key_valid`.
  - Else if `cnt`==CNT_MAX-1: go to IDLE, clear `key_held`, set `ptr`←sel.
  - Else increment `cnt`.
- **Other keys while busy:** ignored, with no queuing. They are arbitrated on the next IDLE cycle only if still high.
- **Simultaneous presses:** resolved in IDLE by the round-robin search. Exactly one key is granted per IDLE→SETTLE transition.
- **`key_code`:** holds its value until the next grant.
- **`busy`:** may be decoded combinationally from the state.
- **Counter bound:** `cnt` never exceeds CNT_MAX-1, so there is no wrap-around.
- **Reset values:**
  - State = IDLE, `cnt`=0, `sel`=0, `ptr`=N_KEYS-1 (so the first search starts at key 0).
  - Synchroniser flops = 0.
  - `key_valid`=0, `key_code`=0, `key_held`=0, `busy`=0.
- **Reset mid-operation:** asserting `rst_n` low forces all of the above immediately, with no emitted pulse. After deassertion, a held key is re-qualified from scratch.

## Timing
- Let edge k be the first edge that samples `key_raw[i]` high.
  - `key_s[i]` is high after edge k+1.
  - IDLE→SETTLE occurs at edge k+2.
  - SETTLE→PRESSED occurs at edge k+2+CNT_MAX.
  - `key_valid` is high for exactly the one cycle following that edge.
- Press latency is therefore CNT_MAX+2 cycles, given continuously high input.
- Let edge r be the first edge that samples the key low.
  - PRESSED→RELEASE occurs at edge r+2.
  - `key_held` clears and `busy` drops at edge r+2+CNT_MAX.
- Minimum spacing between two `key_valid` pulses is 2·CNT_MAX+4 cycles.
- A single low sample in SETTLE, or a single high sample in RELEASE, restarts qualification.

## Test plan
All scenarios use CNT_MAX=4 and N_KEYS=4.
1. **Reset:** assert `rst_n`=0 with `key_raw`=4'b1111 → all outputs 0. Release reset while keys stay high → `key_code`=0, and `key_valid` fires 6 cycles after the first sampled-high edge.
2. **Clean press:** `key_raw[1]` high for 20 cycles, then low → exactly one `key_valid` at edge k+6 with `key_code`=1. `key_held`=4'b0010 from edge k+6 until edge r+6. `busy` is high from edge k+2 to edge r+6.
3. **Bouncy press:** `key_raw[0]` driven 1,1,1,0,1,1,0 then steady 1 → no pulse during the bounce. A single pulse occurs 6 cycles after the start of the steady-1 run.
4. **Release bounce:** after acceptance of key 3, drive `key_raw[3]` 0,0,1,0 then steady 0 → returns to PRESSED, no second `key_valid`, and `key_held` stays 4'b1000 until 4 stable-low cycles after the reset of the RELEASE counter.
5. **Round-robin:** keys 0 and 2 rise together and stay high → key 0 is granted first. After key 0 releases, key 2 is granted (`key_code`=2). Next, keys 0 and 2 rise together again → key 0 is granted (ptr=2, search 3→0).
6. **Reset mid-SETTLE:** pulse `rst_n` low at `cnt`=2 → `busy`, `key_valid` and `key_held` are 0 immediately. No pulse is emitted for the aborted press.
